// File: rtl/lsu_byte_bus_pkg.sv
// rtl/lsu_byte_bus_pkg.sv - shared memory access mode codes, LSU states and helpers
package lsu_byte_bus_pkg;

    localparam logic [2:0] MEM_MODE_WORD       = 3'd0;
    localparam logic [2:0] MEM_MODE_BYTE       = 3'd1;
    localparam logic [2:0] MEM_MODE_BYTE_SIGN  = 3'd2;
    localparam logic [2:0] MEM_MODE_HWORD      = 3'd3;
    localparam logic [2:0] MEM_MODE_HWORD_SIGN = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CHECK = 2'd1,
        ST_XFER  = 2'd2,
        ST_FIN   = 2'd3
    } lsu_state_e;

    // Codes above HWORD_SIGN are unassigned and handled as a fault.
    function automatic logic mode_legal(input logic [2:0] mode);
        return (mode <= MEM_MODE_HWORD_SIGN);
    endfunction

    // Index of the final byte of an access (byte count minus one).
    function automatic logic [1:0] mode_last_idx(input logic [2:0] mode);
        case (mode)
            MEM_MODE_WORD:                        return 2'd3;
            MEM_MODE_HWORD, MEM_MODE_HWORD_SIGN:  return 2'd1;
            default:                              return 2'd0;
        endcase
    endfunction

    // Natural alignment: words on 4-byte, halfwords on 2-byte boundaries.
    function automatic logic mode_misaligned(input logic [2:0] mode, input logic [1:0] addr_lo);
        case (mode)
            MEM_MODE_WORD:                        return (addr_lo != 2'b00);
            MEM_MODE_HWORD, MEM_MODE_HWORD_SIGN:  return addr_lo[0];
            default:                              return 1'b0;
        endcase
    endfunction

    // Little-endian byte lane select.
    function automatic logic [7:0] get_byte(input logic [31:0] data, input logic [1:0] idx);
        return data[{idx, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/lsu_byte_bus_if.sv
// rtl/lsu_byte_bus_if.sv - byte-wide valid/ready memory bus
interface lsu_byte_bus_if #(
    parameter int ADDR_W = 32
);
    logic              bus_valid;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [7:0]        bus_wdata;
    logic [7:0]        bus_rdata;
    logic              bus_ready;

    modport master (
        output bus_valid, bus_we, bus_addr, bus_wdata,
        input  bus_rdata, bus_ready
    );

    modport slave (
        input  bus_valid, bus_we, bus_addr, bus_wdata,
        output bus_rdata, bus_ready
    );
endinterface

// File: rtl/lsu_extend.sv
// rtl/lsu_extend.sv - zero/sign extension of assembled load data by access mode
module lsu_extend
    import lsu_byte_bus_pkg::*;
(
    input  logic [31:0] data_in,
    input  logic [2:0]  mode,
    output logic [31:0] data_out
);

    // Select the extension rule for the access width and signedness.
    always_comb begin
        data_out = data_in;
        case (mode)
            MEM_MODE_BYTE:       data_out = {24'h000000, data_in[7:0]};
            MEM_MODE_BYTE_SIGN:  data_out = {{24{data_in[7]}}, data_in[7:0]};
            MEM_MODE_HWORD:      data_out = {16'h0000, data_in[15:0]};
            MEM_MODE_HWORD_SIGN: data_out = {{16{data_in[15]}}, data_in[15:0]};
            default:             data_out = data_in;
        endcase
    end

endmodule

// File: rtl/lsu_byte_bus.sv
// rtl/lsu_byte_bus.sv - load/store unit serialising accesses onto a byte bus
module lsu_byte_bus
    import lsu_byte_bus_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int BUS_TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [2:0]        mem_acc_mode,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    output logic              done,
    output logic [31:0]       rdata,
    output logic              err_misalign,
    output logic              err_timeout,
    lsu_byte_bus_if.master    bus
);

    localparam int TMO_W = (BUS_TIMEOUT > 1) ? $clog2(BUS_TIMEOUT + 1) : 1;

    lsu_state_e        state_q, state_d;
    logic              req_ready_q, req_ready_d;
    logic              done_q, done_d;
    logic              err_mis_q, err_mis_d;
    logic              err_tmo_q, err_tmo_d;
    logic              bus_valid_q, bus_valid_d;
    logic              bus_we_q, bus_we_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [7:0]        bus_wdata_q, bus_wdata_d;
    logic [31:0]       rdata_q, rdata_d;
    logic [ADDR_W-1:0] base_q, base_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [2:0]        mode_q, mode_d;
    logic              dir_q, dir_d;
    logic              both_q, both_d;
    logic [1:0]        idx_q, idx_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [31:0]       asm_q, asm_d;

    logic [31:0]       asm_upd;
    logic [31:0]       ext_data;
    logic [TMO_W-1:0]  tmo_inc;
    logic [1:0]        idx_nxt;
    logic              fault;

    // Extension sees the assembly including the byte arriving this cycle,
    // so rdata can be registered on the same edge that enters FIN.
    lsu_extend u_extend (
        .data_in  (asm_upd),
        .mode     (mode_q),
        .data_out (ext_data)
    );

    // Helper values derived from the current state.
    always_comb begin
        asm_upd = asm_q;
        asm_upd[{idx_q, 3'b000} +: 8] = bus.bus_rdata;
        tmo_inc = tmo_q + TMO_W'(1);
        idx_nxt = idx_q + 2'd1;
        fault   = both_q || !mode_legal(mode_q) || mode_misaligned(mode_q, base_q[1:0]);
    end

    // Next-state and registered-output computation for the access sequencer.
    always_comb begin
        state_d     = state_q;
        req_ready_d = req_ready_q;
        done_d      = 1'b0;
        err_mis_d   = 1'b0;
        err_tmo_d   = 1'b0;
        bus_valid_d = bus_valid_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        rdata_d     = rdata_q;
        base_d      = base_q;
        wdata_d     = wdata_q;
        mode_d      = mode_q;
        dir_d       = dir_q;
        both_d      = both_q;
        idx_d       = idx_q;
        tmo_d       = tmo_q;
        asm_d       = asm_q;

        case (state_q)
            ST_IDLE: begin
                req_ready_d = 1'b1;
                // A handshake with neither direction set is swallowed silently.
                if (req_valid && (mem_read || mem_write)) begin
                    base_d      = addr;
                    wdata_d     = wdata;
                    mode_d      = mem_acc_mode;
                    dir_d       = mem_write;
                    both_d      = mem_read && mem_write;
                    req_ready_d = 1'b0;
                    state_d     = ST_CHECK;
                end
            end

            ST_CHECK: begin
                if (fault) begin
                    done_d    = 1'b1;
                    err_mis_d = 1'b1;
                    state_d   = ST_FIN;
                end else begin
                    idx_d       = 2'd0;
                    tmo_d       = '0;
                    asm_d       = 32'h0;
                    bus_valid_d = 1'b1;
                    bus_we_d    = dir_q;
                    bus_addr_d  = base_q;
                    bus_wdata_d = get_byte(wdata_q, 2'd0);
                    state_d     = ST_XFER;
                end
            end

            ST_XFER: begin
                if (bus.bus_ready) begin
                    tmo_d = '0;
                    if (!dir_q) begin
                        asm_d = asm_upd;
                    end
                    if (idx_q == mode_last_idx(mode_q)) begin
                        bus_valid_d = 1'b0;
                        bus_we_d    = 1'b0;
                        done_d      = 1'b1;
                        state_d     = ST_FIN;
                        if (!dir_q) begin
                            rdata_d = ext_data;
                        end
                    end else begin
                        idx_d       = idx_nxt;
                        bus_addr_d  = base_q + ADDR_W'(idx_nxt);
                        bus_wdata_d = get_byte(wdata_q, idx_nxt);
                    end
                end else if (BUS_TIMEOUT != 0) begin
                    // Abort without touching rdata; bytes already stored stay stored.
                    if (tmo_inc == TMO_W'(BUS_TIMEOUT)) begin
                        tmo_d       = '0;
                        bus_valid_d = 1'b0;
                        bus_we_d    = 1'b0;
                        done_d      = 1'b1;
                        err_tmo_d   = 1'b1;
                        state_d     = ST_FIN;
                    end else begin
                        tmo_d = tmo_inc;
                    end
                end
            end

            ST_FIN: begin
                idx_d       = 2'd0;
                req_ready_d = 1'b1;
                state_d     = ST_IDLE;
            end

            default: begin
                req_ready_d = 1'b1;
                bus_valid_d = 1'b0;
                state_d     = ST_IDLE;
            end
        endcase
    end

    // State and output registers; reset drops the bus immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            done_q      <= 1'b0;
            err_mis_q   <= 1'b0;
            err_tmo_q   <= 1'b0;
            bus_valid_q <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= 8'h00;
            rdata_q     <= 32'h0;
            base_q      <= '0;
            wdata_q     <= 32'h0;
            mode_q      <= MEM_MODE_WORD;
            dir_q       <= 1'b0;
            both_q      <= 1'b0;
            idx_q       <= 2'd0;
            tmo_q       <= '0;
            asm_q       <= 32'h0;
        end else begin
            state_q     <= state_d;
            req_ready_q <= req_ready_d;
            done_q      <= done_d;
            err_mis_q   <= err_mis_d;
            err_tmo_q   <= err_tmo_d;
            bus_valid_q <= bus_valid_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            rdata_q     <= rdata_d;
            base_q      <= base_d;
            wdata_q     <= wdata_d;
            mode_q      <= mode_d;
            dir_q       <= dir_d;
            both_q      <= both_d;
            idx_q       <= idx_d;
            tmo_q       <= tmo_d;
            asm_q       <= asm_d;
        end
    end

    assign req_ready     = req_ready_q;
    assign done          = done_q;
    assign rdata         = rdata_q;
    assign err_misalign  = err_mis_q;
    assign err_timeout   = err_tmo_q;
    assign bus.bus_valid = bus_valid_q;
    assign bus.bus_we    = bus_we_q;
    assign bus.bus_addr  = bus_addr_q;
    assign bus.bus_wdata = bus_wdata_q;

endmodule

// File: tb/tb_lsu_byte_bus.sv
// tb/tb_lsu_byte_bus.sv - directed self-checking bench for lsu_byte_bus
module tb_lsu_byte_bus;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  mem_acc_mode;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        done;
    logic [31:0] rdata;
    logic        err_misalign;
    logic        err_timeout;

    int checks   = 0;
    int failures = 0;

    lsu_byte_bus_if #(.ADDR_W(32)) bus_if ();

    lsu_byte_bus #(
        .ADDR_W      (32),
        .BUS_TIMEOUT (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_acc_mode (mem_acc_mode),
        .addr         (addr),
        .wdata        (wdata),
        .done         (done),
        .rdata        (rdata),
        .err_misalign (err_misalign),
        .err_timeout  (err_timeout),
        .bus          (bus_if.master)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s: got 0x%08h want 0x%08h", tag, got, want);
        end
    endtask

    // Issue one request, act as the bus slave, and check the observed transfer.
    // Cycle 1 is the cycle in which the request is presented.
    task automatic do_access(input string name, input logic rd, input logic wr,
                             input logic [2:0] mode, input logic [31:0] a,
                             input logic [31:0] wd, input logic [31:0] rbytes,
                             input int stall_idx, input int stall_n,
                             input int exp_cyc, input logic [31:0] exp_rdata,
                             input logic exp_mis, input logic exp_tmo, input int exp_nb);
        int cyc;
        int nb;
        int stalls;
        int done_cyc;
        int limit;
        logic [31:0] wexp;
        limit = (exp_cyc == 0) ? 8 : 40;
        @(posedge clk); #1;
        chk({name, "_req_ready"}, req_ready, 1);
        req_valid    = 1'b1;
        mem_read     = rd;
        mem_write    = wr;
        mem_acc_mode = mode;
        addr         = a;
        wdata        = wd;
        bus_if.bus_ready = 1'b0;
        cyc = 1; nb = 0; stalls = 0; done_cyc = 0;
        while (cyc < limit && done_cyc == 0) begin
            @(posedge clk); #1;
            cyc++;
            req_valid = 1'b0;
            mem_read  = 1'b0;
            mem_write = 1'b0;
            if (done) begin
                done_cyc = cyc;
                chk({name, "_rdata"}, rdata, exp_rdata);
                chk({name, "_err_mis"}, err_misalign, exp_mis);
                chk({name, "_err_tmo"}, err_timeout, exp_tmo);
            end
            if (bus_if.bus_valid) begin
                chk({name, "_addr"}, bus_if.bus_addr, a + nb);
                chk({name, "_we"}, bus_if.bus_we, wr);
                if (wr) begin
                    wexp = (wd >> (8 * nb)) & 32'hFF;
                    chk({name, "_wdata"}, bus_if.bus_wdata, wexp);
                end
                if (nb == stall_idx && stalls < stall_n) begin
                    bus_if.bus_ready = 1'b0;
                    stalls++;
                end else begin
                    bus_if.bus_ready = 1'b1;
                    bus_if.bus_rdata = rbytes[8*nb +: 8];
                    nb++;
                end
            end else begin
                bus_if.bus_ready = 1'b0;
            end
        end
        chk({name, "_done_cycle"}, done_cyc, exp_cyc);
        chk({name, "_nbytes"}, nb, exp_nb);
        @(posedge clk); #1;
        chk({name, "_done_pulse"}, done, 0);
        chk({name, "_ready_after"}, req_ready, 1);
        chk({name, "_bus_idle"}, bus_if.bus_valid, 0);
    endtask

    initial begin
        int n;
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        mem_read     = 1'b0;
        mem_write    = 1'b0;
        mem_acc_mode = 3'd0;
        addr         = 32'h0;
        wdata        = 32'h0;
        bus_if.bus_ready = 1'b0;
        bus_if.bus_rdata = 8'h00;

        repeat (2) @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_bus_valid", bus_if.bus_valid, 0);
        chk("rst_bus_addr", bus_if.bus_addr, 0);
        chk("rst_rdata", rdata, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // name rd wr mode addr wdata rbytes stall_idx stall_n cyc rdata mis tmo nb
        do_access("lw",    1, 0, 3'd0, 32'h100, 32'h0, 32'h12345678, 9, 0, 7, 32'h12345678, 0, 0, 4);
        do_access("lb",    1, 0, 3'd2, 32'h203, 32'h0, 32'h00000080, 9, 0, 4, 32'hFFFFFF80, 0, 0, 1);
        do_access("lbu",   1, 0, 3'd1, 32'h203, 32'h0, 32'h00000080, 9, 0, 4, 32'h00000080, 0, 0, 1);
        do_access("lh",    1, 0, 3'd4, 32'h010, 32'h0, 32'h00008000, 9, 0, 5, 32'hFFFF8000, 0, 0, 2);
        do_access("sw",    0, 1, 3'd0, 32'h040, 32'hDEADBEEF, 32'h0, 1, 3, 10, 32'hFFFF8000, 0, 0, 4);
        do_access("lw_mis",1, 0, 3'd0, 32'h102, 32'h0, 32'h0, 9, 0, 3, 32'hFFFF8000, 1, 0, 0);
        do_access("sh_mis",0, 1, 3'd3, 32'h007, 32'h1234, 32'h0, 9, 0, 3, 32'hFFFF8000, 1, 0, 0);
        do_access("lw_tmo",1, 0, 3'd0, 32'h300, 32'h0, 32'h0, 0, 99, 7, 32'hFFFF8000, 0, 1, 0);
        do_access("nop",   0, 0, 3'd0, 32'h500, 32'h0, 32'h0, 9, 0, 0, 32'hFFFF8000, 0, 0, 0);
        do_access("bad_md",1, 0, 3'd5, 32'h600, 32'h0, 32'h0, 9, 0, 3, 32'hFFFF8000, 1, 0, 0);
        do_access("rd_wr", 1, 1, 3'd0, 32'h000, 32'h0, 32'h0, 9, 0, 3, 32'hFFFF8000, 1, 0, 0);

        // Reset in the middle of a stalled store.
        @(posedge clk); #1;
        req_valid    = 1'b1;
        mem_write    = 1'b1;
        mem_acc_mode = 3'd0;
        addr         = 32'h80;
        wdata        = 32'h11223344;
        bus_if.bus_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        mem_write = 1'b0;
        n = 0;
        while (!bus_if.bus_valid && n < 5) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rst_mid_valid_before", bus_if.bus_valid, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_bus_valid", bus_if.bus_valid, 0);
        chk("rst_mid_bus_we", bus_if.bus_we, 0);
        chk("rst_mid_bus_addr", bus_if.bus_addr, 0);
        chk("rst_mid_bus_wdata", bus_if.bus_wdata, 0);
        chk("rst_mid_done", done, 0);
        chk("rst_mid_req_ready", req_ready, 1);
        chk("rst_mid_rdata", rdata, 0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        do_access("lbu_after_rst", 1, 0, 3'd1, 32'h005, 32'h0, 32'h0000009A, 9, 0, 4, 32'h0000009A, 0, 0, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
